// File: rtl/conv_window_streamer.sv
// conv_window_streamer
//   Sequencer that sits directly after the receptive-field selector. It walks
//   every output row, first the left half and then the right half of the output
//   columns. For each half it drives rowNumber/column to the selector, captures
//   the selector's half-row of receptive fields, and streams them one window per
//   valid/ready handshake to the MAC/PE stage. It pulses done once the last
//   window of the frame has been accepted.
//
//   Optional build macro: CONV_STALL_COUNT_EN adds the stall_cycles port, a
//   saturating count of cycles with window_valid=1 and window_ready=0.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   start          one-cycle frame start request (ignored unless idle)
//   receptiveField selector output, HALF windows, big-endian [0:HALF*WIN-1]
//   rowNumber      to selector: current output row
//   column         to selector: 0 = first half, 1 = second half
//   window_data    current window, big-endian [0:WIN-1]
//   window_valid   window_data/window_row/window_col valid
//   window_ready   downstream accepts the current window
//   window_row     output row of the current window
//   window_col     output column of the current window, 0..N-1
//   busy           frame in progress (SELECT/STREAM)
//   done           one-cycle pulse after the last window is accepted
//   stall_cycles   (CONV_STALL_COUNT_EN only) saturating stall count
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// SELECT | selector inputs stable for one cycle; capture at cycle end
// STREAM | present captured windows one per handshake
// FINISH | one-cycle done pulse, then back to IDLE
module conv_window_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  localparam int N         = W - F + 1,
  localparam int HALF      = N / 2,
  localparam int WIN       = D * F * F * DATA_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [0:HALF*WIN-1] receptiveField,
  output logic [5:0]          rowNumber,
  output logic [5:0]          column,
  output logic [0:WIN-1]      window_data,
  output logic                window_valid,
  input  logic                window_ready,
  output logic [5:0]          window_row,
  output logic [5:0]          window_col,
  output logic                busy,
  output logic                done
`ifdef CONV_STALL_COUNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  localparam int              IDXW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(HALF - 1);
  localparam logic [5:0]      ROW_LAST = 6'(H - F);
  localparam logic [5:0]      HALF_OFS = 6'(HALF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          row_q, row_d;
  logic                col_q, col_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [0:HALF*WIN-1] cap_buf;
  logic                capture;

  // State and index registers; cap_buf loads at the end of the SELECT cycle,
  // by which time the selector has settled on the stable rowNumber/column.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= 1'b0;
      idx_q   <= '0;
      cap_buf <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      if (capture) begin
        cap_buf <= receptiveField;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    idx_d        = idx_q;
    capture      = 1'b0;
    window_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = 1'b0;
          idx_d   = '0;
          state_d = SELECT;
        end
      end

      SELECT: begin
        busy    = 1'b1;
        capture = 1'b1;
        state_d = STREAM;
      end

      STREAM: begin
        busy         = 1'b1;
        window_valid = 1'b1;
        if (window_ready) begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + IDXW'(1);
          end else if (!col_q) begin
            col_d   = 1'b1;
            idx_d   = '0;
            state_d = SELECT;
          end else if (row_q != ROW_LAST) begin
            row_d   = row_q + 6'd1;
            col_d   = 1'b0;
            idx_d   = '0;
            state_d = SELECT;
          end else begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rowNumber  = row_q;
  assign column     = {5'b0, col_q};
  assign window_row = row_q;
  assign window_col = col_q ? (HALF_OFS + 6'(idx_q)) : 6'(idx_q);

  // Constant-index mux keeps the window select free of wide dynamic indexing.
  always_comb begin
    window_data = '0;
    for (int k = 0; k < HALF; k++) begin
      if (idx_q == IDXW'(k)) begin
        window_data = cap_buf[k*WIN +: WIN];
      end
    end
  end

`ifdef CONV_STALL_COUNT_EN
  logic [15:0] stall_q;

  // Cleared only by reset or an accepted start, so it still reads the
  // previous frame's total after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (window_valid && !window_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_conv_window_streamer.sv
module tb_conv_window_streamer;

  localparam int DW    = 16;
  // Small configuration: 8x8 image, 3x3 kernel
  localparam int SH    = 8;
  localparam int SW    = 8;
  localparam int SF    = 3;
  localparam int SN    = SW - SF + 1;
  localparam int SHALF = SN / 2;
  localparam int SWIN  = SF * SF * DW;
  localparam int STOT  = (SH - SF + 1) * SN;
  // Default configuration: 32x32 image, 5x5 kernel
  localparam int BH    = 32;
  localparam int BW    = 32;
  localparam int BF    = 5;
  localparam int BN    = BW - BF + 1;
  localparam int BHALF = BN / 2;
  localparam int BWIN  = BF * BF * DW;
  localparam int BTOT  = (BH - BF + 1) * BN;

  typedef struct {
    int r;
    int c;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_s, ready_s, start_b, ready_b;

  logic [0:SHALF*SWIN-1] rf_s;
  logic [5:0]            rown_s, col_s, wrow_s, wcol_s;
  logic [0:SWIN-1]       wd_s;
  logic                  wv_s, busy_s, done_s;
  logic [0:BHALF*BWIN-1] rf_b;
  logic [5:0]            rown_b, col_b, wrow_b, wcol_b;
  logic [0:BWIN-1]       wd_b;
  logic                  wv_b, busy_b, done_b;
`ifdef CONV_STALL_COUNT_EN
  logic [15:0]           stall_s, stall_b;
`endif

  int n_total = 0;
  int n_pass  = 0;

  conv_window_streamer #(.DATA_WIDTH(DW), .D(1), .H(SH), .W(SW), .F(SF)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .receptiveField(rf_s),
    .rowNumber(rown_s), .column(col_s), .window_data(wd_s), .window_valid(wv_s),
    .window_ready(ready_s), .window_row(wrow_s), .window_col(wcol_s),
    .busy(busy_s), .done(done_s)
`ifdef CONV_STALL_COUNT_EN
    , .stall_cycles(stall_s)
`endif
  );

  conv_window_streamer #(.DATA_WIDTH(DW), .D(1), .H(BH), .W(BW), .F(BF)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .receptiveField(rf_b),
    .rowNumber(rown_b), .column(col_b), .window_data(wd_b), .window_valid(wv_b),
    .window_ready(ready_b), .window_row(wrow_b), .window_col(wcol_b),
    .busy(busy_b), .done(done_b)
`ifdef CONV_STALL_COUNT_EN
    , .stall_cycles(stall_b)
`endif
  );

  // Selector models: pixel(row, col) = W*row + col; window k of the half
  // covers output column column*HALF + k, pixels laid out row-major.
  always_comb begin
    rf_s = '0;
    for (int k = 0; k < SHALF; k++)
      for (int i = 0; i < SF; i++)
        for (int j = 0; j < SF; j++)
          rf_s[(k*SWIN + (i*SF + j)*DW) +: DW] =
            16'(SW*(int'(rown_s) + i) + int'(col_s)*SHALF + k + j);
  end

  always_comb begin
    rf_b = '0;
    for (int k = 0; k < BHALF; k++)
      for (int i = 0; i < BF; i++)
        for (int j = 0; j < BF; j++)
          rf_b[(k*BWIN + (i*BF + j)*DW) +: DW] =
            16'(BW*(int'(rown_b) + i) + int'(col_b)*BHALF + k + j);
  end

  // Reference window: first pixel is the most significant chunk.
  function automatic logic [511:0] exp_win(input int r, input int c, input int wid, input int f);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < f; i++)
      for (int j = 0; j < f; j++)
        v = (v << DW) | 512'(16'(wid*(r + i) + c + j));
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero_s(input string tag);
    check({tag, "_rownumber"}, rown_s, 0);
    check({tag, "_column"}, col_s, 0);
    check({tag, "_data"}, wd_s, 0);
    check({tag, "_tags"}, {wrow_s, wcol_s}, 0);
    check({tag, "_valid_busy_done"}, {wv_s, busy_s, done_s}, 0);
`ifdef CONV_STALL_COUNT_EN
    check({tag, "_stall"}, stall_s, 0);
`endif
  endtask

  // One frame on the small DUT. mode: 0 ready high, 1 ready toggling,
  // 2 ready random. reset_at: index of window whose handshake cycle also
  // asserts reset (-1 none). restart_at: cycle of a spurious start pulse.
  task automatic run_small(input int mode, input int reset_at, input int restart_at,
                           output int n_win, output int n_done, output int done_k,
                           output int stalls);
    win_t            q[$];
    int              k;
    logic            rdy, tog, prev_stall, got_reset;
    logic [0:SWIN-1] p_wd;
    logic [11:0]     p_tag;
    n_win = 0; n_done = 0; done_k = -1; stalls = 0;
    tog = 1'b1; prev_stall = 1'b0; got_reset = 1'b0; p_wd = '0; p_tag = '0;
    for (int r = 0; r <= SH - SF; r++)
      for (int c = 0; c < SN; c++)
        q.push_back('{r, c});
    start_s = 1'b1;
    @(posedge clk); @(negedge clk);
    start_s = 1'b0;
    k = 1;
    check("select_after_start", {wv_s, busy_s}, 2'b01);
    while (k < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_s = rdy;
      start_s = (k == restart_at);
      if (busy_s && !wv_s && q.size() > 0) begin
        check("select_row", rown_s, q[0].r);
        check("select_col", col_s, q[0].c / SHALF);
      end
      if (wv_s) begin
        if (prev_stall) begin
          check("hold_data", wd_s, p_wd);
          check("hold_tags", {wrow_s, wcol_s}, p_tag);
        end
        if (rdy) begin
          if (q.size() == 0) begin
            check("window_count", n_win + 1, STOT);
          end else begin
            if (n_win == reset_at) reset = 1'b1;
            check("win_row", wrow_s, q[0].r);
            check("win_col", wcol_s, q[0].c);
            check("win_data", wd_s, exp_win(q[0].r, q[0].c, SW, SF));
            q.delete(0);
            n_win++;
          end
        end else begin
          stalls++;
        end
      end
      prev_stall = wv_s && !rdy;
      p_wd  = wd_s;
      p_tag = {wrow_s, wcol_s};
      if (done_s) begin
        n_done++;
        done_k = k;
        check("done_valid_low", wv_s, 0);
        check("done_busy_low", busy_s, 0);
        check("done_all_windows", q.size(), 0);
      end
      @(posedge clk); @(negedge clk);
      k++;
      if (reset) begin
        reset = 1'b0;
        got_reset = 1'b1;
        check_zero_s("after_reset");
        break;
      end
      if (done_k > 0 && k > done_k + 3) break;
    end
    start_s = 1'b0;
    if (!got_reset && done_k < 0) check("frame_timeout", k, 0);
  endtask

  initial begin
    int nw, nd, dk, st, k, er, ec, nb;
    logic seen_done;
    reset = 1'b1; start_s = 1'b0; ready_s = 1'b0; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_s("reset_state");
    check("reset_state_big", {wv_b, busy_b, done_b, rown_b, col_b}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Ready always high: 36 windows, done exactly one frame length after SELECT.
    run_small(0, -1, -1, nw, nd, dk, st);
    check("full_windows", nw, STOT);
    check("full_done_count", nd, 1);
    check("full_done_cycle", dk, 1 + 2*(SH - SF + 1)*(1 + SHALF));
`ifdef CONV_STALL_COUNT_EN
    check("full_stall", stall_s, 0);
`endif

    // Ready toggling every cycle.
    run_small(1, -1, -1, nw, nd, dk, st);
    check("toggle_windows", nw, STOT);
    check("toggle_done_count", nd, 1);
`ifdef CONV_STALL_COUNT_EN
    check("toggle_stall", stall_s, st);
`endif

    // Reset on the handshake of window (2,4): abandons the frame.
    run_small(2, 2*SN + 4, -1, nw, nd, dk, st);
    check("reset_no_done", nd, 0);
    check("reset_windows_before", nw, 2*SN + 5);
    for (int i = 0; i < 3; i++) begin
      check("reset_idle", {wv_s, busy_s, done_s}, 0);
      @(negedge clk);
    end

    // New frame from (0,0) with random ready and a spurious mid-frame start.
    run_small(2, -1, 10, nw, nd, dk, st);
    check("restart_windows", nw, STOT);
    check("restart_done_count", nd, 1);
`ifdef CONV_STALL_COUNT_EN
    check("random_stall", stall_s, st);
`endif

    // Default configuration with ready held high.
    er = 0; ec = 0; nb = 0; seen_done = 1'b0;
    start_b = 1'b1;
    @(posedge clk); @(negedge clk);
    start_b = 1'b0;
    k = 1;
    while (k < 5000 && !seen_done) begin
      if (wv_b) begin
        check("big_tags", {wrow_b, wcol_b}, {6'(er), 6'(ec)});
        check("big_data", wd_b, exp_win(er, ec, BW, BF));
        nb++;
        ec++;
        if (ec == BN) begin ec = 0; er++; end
      end
      if (done_b) begin
        seen_done = 1'b1;
        check("big_windows", nb, BTOT);
        check("big_last_row_passed", er, BH - BF + 1);
        check("big_done_cycle", k, 1 + 2*(BH - BF + 1)*(1 + BHALF));
      end
      @(posedge clk); @(negedge clk);
      k++;
    end
    if (!seen_done) check("big_timeout", k, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
